// File: rtl/c1_pkg.sv
// Shared C1 bus definitions, used by the CPU-side initiator and the cache-side responder.
package c1_pkg;
  localparam int CACHE_TAG_SIZE    = 10;
  localparam int CACHE_SET_SIZE    = 5;
  localparam int CACHE_OFFSET_SIZE = 4;
  localparam int DATA1_BUS_SIZE    = 16;
  localparam int BITS_IN_BYTE      = 8;
  localparam int ADDR1_W           = CACHE_TAG_SIZE + CACHE_SET_SIZE;
  localparam int REQ_ADDR_W        = ADDR1_W + CACHE_OFFSET_SIZE;
  localparam int CORE_DATA_W       = 2 * DATA1_BUS_SIZE;

  typedef logic [2:0] c1_cmd_t;

  localparam c1_cmd_t C1_NOP             = 3'd0;
  localparam c1_cmd_t C1_READ8           = 3'd1;
  localparam c1_cmd_t C1_READ16          = 3'd2;
  localparam c1_cmd_t C1_READ32          = 3'd3;
  localparam c1_cmd_t C1_INVALIDATE_LINE = 3'd4;
  localparam c1_cmd_t C1_WRITE8          = 3'd5;
  localparam c1_cmd_t C1_WRITE16         = 3'd6;
  localparam c1_cmd_t C1_WRITE32         = 3'd7;
  // Responder reuses the WRITE32 encoding once it owns the bus.
  localparam c1_cmd_t C1_RESPONSE        = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RECV2, ST_ISSUE, ST_WAIT, ST_RESP1, ST_RESP2, ST_DONE
  } c1_state_t;

  typedef struct packed {
    c1_cmd_t                cmd;
    logic [REQ_ADDR_W-1:0]  addr;
    logic [CORE_DATA_W-1:0] wdata;
  } c1_req_t;

  function automatic logic is_read(input c1_cmd_t cmd);
    return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
  endfunction

  function automatic logic is_write(input c1_cmd_t cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  function automatic logic is_request(input c1_cmd_t cmd);
    return is_read(cmd) || is_write(cmd) || (cmd == C1_INVALIDATE_LINE);
  endfunction

  function automatic logic [1:0] resp_ticks(input c1_cmd_t cmd);
    return (cmd == C1_READ32) ? 2'd2 : 2'd1;
  endfunction
endpackage

// File: rtl/c1_req_decoder.sv
// Captures the two-tick C1 request into one flat, registered core request.
module c1_req_decoder
  import c1_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cap1,
  input  logic                      cap2,
  input  c1_cmd_t                   c1_in,
  input  logic [ADDR1_W-1:0]        a1_in,
  input  logic [DATA1_BUS_SIZE-1:0] d1_in,
  output c1_req_t                   req
);
  always_ff @(posedge clk) begin
    if (reset) begin
      req <= '0;
    end else if (cap1) begin
      req.cmd   <= c1_in;
      req.addr  <= {a1_in, {CACHE_OFFSET_SIZE{1'b0}}};
      req.wdata <= {{DATA1_BUS_SIZE{1'b0}}, d1_in};
    end else if (cap2) begin
      req.addr[CACHE_OFFSET_SIZE-1:0] <= a1_in[CACHE_OFFSET_SIZE-1:0];
      if (req.cmd == C1_WRITE32)
        req.wdata[CORE_DATA_W-1:DATA1_BUS_SIZE] <= d1_in;
      else if (req.cmd == C1_WRITE8)
        req.wdata <= {{(CORE_DATA_W-BITS_IN_BYTE){1'b0}}, req.wdata[BITS_IN_BYTE-1:0]};
    end
  end
endmodule

// File: rtl/c1_bus_responder.sv
// Cache-side C1 responder: decodes the request, hands it to the core, drives the response ticks.
module c1_bus_responder
  import c1_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                c1_in,
  input  logic [ADDR1_W-1:0]        a1_in,
  input  logic [DATA1_BUS_SIZE-1:0] d1_in,
  output logic [2:0]                c1_out,
  output logic [DATA1_BUS_SIZE-1:0] d1_out,
  output logic                      bus_oe,
  output logic                      req_valid,
  output logic [2:0]                req_cmd,
  output logic [REQ_ADDR_W-1:0]     req_addr,
  output logic [CORE_DATA_W-1:0]    req_wdata,
  input  logic                      req_ready,
  input  logic                      rsp_valid,
  input  logic [CORE_DATA_W-1:0]    rsp_rdata,
  output logic                      busy,
  output logic [31:0]               txn_count
);
  c1_state_t                 state;
  c1_req_t                   req;
  logic [DATA1_BUS_SIZE-1:0] rdata_hi;

  c1_req_decoder u_dec (
    .clk   (clk),
    .reset (reset),
    .cap1  ((state == ST_IDLE) && is_request(c1_in)),
    .cap2  (state == ST_RECV2),
    .c1_in (c1_in),
    .a1_in (a1_in),
    .d1_in (d1_in),
    .req   (req)
  );

  assign req_cmd   = req.cmd;
  assign req_addr  = req.addr;
  assign req_wdata = req.wdata;
  assign busy      = (state != ST_IDLE);

  function automatic logic [DATA1_BUS_SIZE-1:0] first_word(input c1_cmd_t cmd,
                                                           input logic [CORE_DATA_W-1:0] d);
    if (cmd == C1_READ8)                      return {{(DATA1_BUS_SIZE-BITS_IN_BYTE){1'b0}}, d[BITS_IN_BYTE-1:0]};
    if (cmd == C1_READ16 || cmd == C1_READ32) return d[DATA1_BUS_SIZE-1:0];
    return '0;
  endfunction

  // Outputs are loaded on the transition edge so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      c1_out    <= C1_NOP;
      d1_out    <= '0;
      bus_oe    <= 1'b0;
      req_valid <= 1'b0;
      rdata_hi  <= '0;
      txn_count <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (is_request(c1_in)) state <= ST_RECV2;
        ST_RECV2: begin
          state     <= ST_ISSUE;
          req_valid <= 1'b1;
        end
        ST_ISSUE, ST_WAIT: begin
          if (state == ST_ISSUE && req_ready) begin
            req_valid <= 1'b0;
            state     <= ST_WAIT;
          end
          if ((state == ST_ISSUE && req_ready) || state == ST_WAIT) begin
            if (rsp_valid) begin
              state    <= ST_RESP1;
              rdata_hi <= rsp_rdata[CORE_DATA_W-1:DATA1_BUS_SIZE];
              bus_oe   <= 1'b1;
              c1_out   <= C1_RESPONSE;
              d1_out   <= first_word(req.cmd, rsp_rdata);
            end
          end
        end
        ST_RESP1: begin
          if (resp_ticks(req.cmd) == 2'd2) begin
            state  <= ST_RESP2;
            d1_out <= rdata_hi;
          end else begin
            state  <= ST_DONE;
            bus_oe <= 1'b0;
            c1_out <= C1_NOP;
            d1_out <= '0;
          end
        end
        ST_RESP2: begin
          state  <= ST_DONE;
          bus_oe <= 1'b0;
          c1_out <= C1_NOP;
          d1_out <= '0;
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          txn_count <= txn_count + 32'd1;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule
